lsu: RTL and testbench
======================

# lsu

Load/store unit for the single-cycle core: sits directly downstream of the execution unit, taking its ALU result as the effective address and `rs2` data as store data. It converts one load or store into a request/response transaction on a simple memory bus and holds the core stalled until the access completes. It returns byte-aligned, sign- or zero-extended load data for register writeback and flags misaligned or illegal accesses without touching the bus.

## Interface
- `XLEN`, 32, data/address width; only 32 is supported.
- `MEMOP_W`, 3, width of `mem_opcode` (funct3 encoding).
- `clk` in 1: core clock, all state on rising edge.
- `rst_b` in 1: reset, asynchronous and active-low.
- `lsu_valid` in 1: execution unit presents a memory instruction this cycle.
- `lsu_write` in 1: 1 = store, 0 = load.
- `mem_opcode` in MEMOP_W: 000 B, 001 H, 010 W, 100 BU, 101 HU; BU/HU are legal for loads only.
- `lsu_addr` in XLEN: effective address (ALU result).
- `lsu_wdata` in XLEN: store data (`rs2`).
- `lsu_busy` out 1: stall request to the core.
- `lsu_done` out 1: one-cycle completion pulse.
- `lsu_rdata` out XLEN: extended load data, valid with `lsu_done`.
- `lsu_misalign` out 1: with `lsu_done`, marks a misaligned or illegal access.
- `mem_req` out 1: bus request.
- `mem_ready` in 1: bus accepts the request.
- `mem_we` out 1: bus write.
- `mem_addr` out XLEN: word-aligned bus address.
- `mem_wdata` out XLEN: bus write data.
- `mem_wstrb` out XLEN/8: byte enables.
- `mem_rvalid` in 1: bus response (read data or write acknowledge).
- `mem_rdata` in XLEN: bus read data.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. Reset enters IDLE.
- **IDLE**
  - On `lsu_valid`, register the address, opcode, write flag and formatted store data.
  - Aligned and legal access: go to REQ.
  - Otherwise: go to DONE with the error flag set. No bus activity.
- **REQ**
  - `mem_req`=1; bus signals come from registers and are stable.
  - On `mem_ready`, go to WAIT. Otherwise hold in REQ with all bus outputs unchanged.
- **WAIT**
  - `mem_req`=0.
  - On `mem_rvalid`, capture the extended load data (stores capture 0) and go to DONE.
- **DONE**
  - `lsu_done`=1 for one cycle; `lsu_misalign` reflects the error flag.
  - Always go to IDLE.
- **Alignment rules**
  - H/HU need `addr[0]`=0.
  - W needs `addr[1:0]`=00.
  - Opcodes 011, 110, 111, and store with BU/HU, are illegal.
  - Error completions return `lsu_rdata`=0.
- **Bus formatting**
  - `mem_addr` = {`addr[31:2]`, 00}.
  - SB: wdata = byte replicated ×4, wstrb = 0001 << `addr[1:0]`.
  - SH: wdata = half replicated ×2, wstrb = 0011 << `addr[1:0]`.
  - SW: wdata unchanged, wstrb = 1111.
  - Loads: `mem_we`=0, wstrb=0.
- **Load extraction**
  - Shift `mem_rdata` right by `addr[1:0]`×8.
  - B/H: sign-extend from bit 7/15.
  - BU/HU: zero-extend.
- **Busy:** `lsu_busy` = (IDLE & `lsu_valid`) | REQ | WAIT. It is 0 in DONE so the core advances with `lsu_rdata`.
- **Ignored inputs**
  - `lsu_valid` outside IDLE is ignored.
  - `mem_ready` outside REQ and `mem_rvalid` outside WAIT are ignored, including a stray response after reset.

## Timing
- Reset value of every output is 0: `lsu_busy` (absent `lsu_valid`), `lsu_done`, `lsu_rdata`, `lsu_misalign`, `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb`.
- Accept at cycle T:
  - T+1 `mem_req`=1.
  - `mem_ready` at T+1 gives WAIT at T+2.
  - `mem_rvalid` at T+2 gives `lsu_done` at T+3.
  - Minimum latency is 3 cycles; each stall cycle on `mem_ready` or `mem_rvalid` adds one.
- Error path: accept at T, `lsu_done`=`lsu_misalign`=1 at T+1.
- A new access can be accepted at T+4 (IDLE), one cycle after DONE.
- `mem_req` never asserts in the same cycle as `lsu_valid`; the bus sees registered outputs only.
- Reset asserted in any state:
  - Immediately forces IDLE and all outputs to 0, with `mem_req` dropping asynchronously.
  - The pending transaction is abandoned.

## Test plan
- LW `addr`=0x100, `mem_rdata`=0xDEADBEEF, ready/rvalid zero-wait → `mem_addr`=0x100, `wstrb`=0, `lsu_done` at T+3, `lsu_rdata`=0xDEADBEEF.
- LB `addr`=0x103 / LBU `addr`=0x103, `mem_rdata`=0x80112233 → `lsu_rdata`=0xFFFFFF80 / 0x00000080.
- SH `addr`=0x202, `wdata`=0x1234ABCD → `mem_addr`=0x200, `mem_wdata`=0xABCDABCD, `wstrb`=1100, `mem_we`=1.
- LW `addr`=0x101, and SB with opcode 100 → no `mem_req`, `lsu_done`=`lsu_misalign`=1 at T+1, `lsu_rdata`=0.
- `mem_ready` low 3 cycles, `mem_rvalid` low 2 cycles → `mem_req` held 4 cycles with stable addr/data/strb, `lsu_busy` high throughout, `lsu_done` at T+8.
- `rst_b` pulsed low in WAIT, then `mem_rvalid` arrives → outputs 0, FSM IDLE, no `lsu_done`; next LW completes normally.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: turns one core memory instruction into a req/resp bus transaction,
// stalling the core until it completes and returning extended load data.
module lsu #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned MEMOP_W = 3
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic                lsu_valid,
    input  logic                lsu_write,
    input  logic [MEMOP_W-1:0]  mem_opcode,
    input  logic [XLEN-1:0]     lsu_addr,
    input  logic [XLEN-1:0]     lsu_wdata,
    output logic                lsu_busy,
    output logic                lsu_done,
    output logic [XLEN-1:0]     lsu_rdata,
    output logic                lsu_misalign,
    output logic                mem_req,
    input  logic                mem_ready,
    output logic                mem_we,
    output logic [XLEN-1:0]     mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_wstrb,
    input  logic                mem_rvalid,
    input  logic [XLEN-1:0]     mem_rdata
);

    localparam int unsigned STRB_W = XLEN / 8;

    localparam logic [MEMOP_W-1:0] OP_B  = MEMOP_W'(0);
    localparam logic [MEMOP_W-1:0] OP_H  = MEMOP_W'(1);
    localparam logic [MEMOP_W-1:0] OP_W  = MEMOP_W'(2);
    localparam logic [MEMOP_W-1:0] OP_BU = MEMOP_W'(4);
    localparam logic [MEMOP_W-1:0] OP_HU = MEMOP_W'(5);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t               state_q, state_d;
    logic [1:0]           addr_lo_q, addr_lo_d;
    logic [MEMOP_W-1:0]   op_q, op_d;
    logic                 req_d, we_d, done_d, misalign_d;
    logic [XLEN-1:0]      addr_d, wdata_d, rdata_d;
    logic [STRB_W-1:0]    strb_d;

    logic                 legal_c;
    logic [XLEN-1:0]      fmt_wdata_c, shifted_c, load_ext_c;
    logic [STRB_W-1:0]    fmt_strb_c;

    assign lsu_busy = ((state_q == IDLE) && lsu_valid) || (state_q == REQ) || (state_q == WAIT);

    // Legality check and store formatting of the incoming instruction
    always_comb begin
        legal_c     = 1'b0;
        fmt_wdata_c = lsu_wdata;
        fmt_strb_c  = '1;
        case (mem_opcode)
            OP_B:    legal_c = 1'b1;
            OP_H:    legal_c = !lsu_addr[0];
            OP_W:    legal_c = (lsu_addr[1:0] == 2'b00);
            OP_BU:   legal_c = !lsu_write;
            OP_HU:   legal_c = !lsu_write && !lsu_addr[0];
            default: legal_c = 1'b0;
        endcase
        case (mem_opcode[1:0])
            2'b00: begin
                fmt_wdata_c = {(XLEN/8){lsu_wdata[7:0]}};
                fmt_strb_c  = STRB_W'(1) << lsu_addr[1:0];
            end
            2'b01: begin
                fmt_wdata_c = {(XLEN/16){lsu_wdata[15:0]}};
                fmt_strb_c  = STRB_W'(3) << lsu_addr[1:0];
            end
            default: begin
                fmt_wdata_c = lsu_wdata;
                fmt_strb_c  = '1;
            end
        endcase
    end

    // Byte-lane alignment and extension of the bus read data
    always_comb begin
        shifted_c  = mem_rdata >> {addr_lo_q, 3'b000};
        load_ext_c = shifted_c;
        case (op_q[1:0])
            2'b00:   load_ext_c = op_q[2] ? {{(XLEN-8){1'b0}}, shifted_c[7:0]}
                                          : {{(XLEN-8){shifted_c[7]}}, shifted_c[7:0]};
            2'b01:   load_ext_c = op_q[2] ? {{(XLEN-16){1'b0}}, shifted_c[15:0]}
                                          : {{(XLEN-16){shifted_c[15]}}, shifted_c[15:0]};
            default: load_ext_c = shifted_c;
        endcase
    end

    // Next state and next register values
    always_comb begin
        state_d    = state_q;
        addr_lo_d  = addr_lo_q;
        op_d       = op_q;
        req_d      = 1'b0;
        we_d       = mem_we;
        addr_d     = mem_addr;
        wdata_d    = mem_wdata;
        strb_d     = mem_wstrb;
        done_d     = 1'b0;
        misalign_d = 1'b0;
        rdata_d    = lsu_rdata;
        case (state_q)
            IDLE: begin
                if (lsu_valid) begin
                    op_d      = mem_opcode;
                    addr_lo_d = lsu_addr[1:0];
                    rdata_d   = '0;
                    if (legal_c) begin
                        state_d = REQ;
                        req_d   = 1'b1;
                        we_d    = lsu_write;
                        addr_d  = {lsu_addr[XLEN-1:2], 2'b00};
                        wdata_d = lsu_write ? fmt_wdata_c : '0;
                        strb_d  = lsu_write ? fmt_strb_c : '0;
                    end else begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        misalign_d = 1'b1;
                    end
                end
            end
            REQ: begin
                req_d = 1'b1;
                if (mem_ready) begin
                    state_d = WAIT;
                    req_d   = 1'b0;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    rdata_d = mem_we ? '0 : load_ext_c;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q      <= IDLE;
            addr_lo_q    <= '0;
            op_q         <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_wstrb    <= '0;
            lsu_done     <= 1'b0;
            lsu_misalign <= 1'b0;
            lsu_rdata    <= '0;
        end else begin
            state_q      <= state_d;
            addr_lo_q    <= addr_lo_d;
            op_q         <= op_d;
            mem_req      <= req_d;
            mem_we       <= we_d;
            mem_addr     <= addr_d;
            mem_wdata    <= wdata_d;
            mem_wstrb    <= strb_d;
            lsu_done     <= done_d;
            lsu_misalign <= misalign_d;
            lsu_rdata    <= rdata_d;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed and randomized loads/stores against a size/offset arithmetic model.
module tb_lsu;

    logic        clk;
    logic        rst_b;
    logic        lsu_valid;
    logic        lsu_write;
    logic [2:0]  mem_opcode;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_busy;
    logic        lsu_done;
    logic [31:0] lsu_rdata;
    logic        lsu_misalign;
    logic        mem_req;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int total;
    int passed;
    int fails;

    lsu #(.XLEN(32), .MEMOP_W(3)) dut (
        .clk(clk), .rst_b(rst_b),
        .lsu_valid(lsu_valid), .lsu_write(lsu_write), .mem_opcode(mem_opcode),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_busy(lsu_busy), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
        .lsu_misalign(lsu_misalign),
        .mem_req(mem_req), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected transaction from access size, signedness and byte offset
    function automatic void model(input logic [2:0] op, input logic wr,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  input logic [31:0] rd, output logic ok,
                                  output logic [31:0] e_addr, output logic [31:0] e_wdata,
                                  output logic [3:0] e_strb, output logic [31:0] e_rdata);
        int size;
        bit sgn;
        int off;
        longint v;
        size = 0;
        sgn  = 1'b0;
        case (op)
            3'd0: begin size = 1; sgn = 1'b1; end
            3'd1: begin size = 2; sgn = 1'b1; end
            3'd2: begin size = 4; sgn = 1'b1; end
            3'd4: size = 1;
            3'd5: size = 2;
            default: size = 0;
        endcase
        off    = int'(a % 4);
        ok     = (size != 0) && !(wr && (op == 3'd4 || op == 3'd5)) && ((a % size) == 0);
        e_addr = a - 32'(off);
        e_strb = wr ? 4'(((1 << size) - 1) << off) : 4'd0;
        if (size == 1)      e_wdata = 32'(wd[7:0]) * 32'h01010101;
        else if (size == 2) e_wdata = 32'(wd[15:0]) * 32'h00010001;
        else                e_wdata = wd;
        if (!ok || wr) begin
            e_rdata = 32'd0;
        end else begin
            v = longint'(rd);
            v = (v >> (8 * off)) & ((longint'(1) << (8 * size)) - 1);
            if (sgn && size < 4 && v >= (longint'(1) << (8 * size - 1)))
                v = v - (longint'(1) << (8 * size));
            e_rdata = 32'(v);
        end
    endfunction

    // One access starting at a negedge with the DUT idle; returns at the negedge after DONE
    task automatic do_access(input logic [2:0] op, input logic wr, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] rd,
                             input int rs, input int vs, input bit noise);
        logic        ok;
        logic [31:0] e_addr, e_wdata, e_rdata;
        logic [3:0]  e_strb;
        int          cyc;
        model(op, wr, a, wd, rd, ok, e_addr, e_wdata, e_strb, e_rdata);
        lsu_valid = 1'b1; lsu_write = wr; mem_opcode = op; lsu_addr = a; lsu_wdata = wd;
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        #1;
        check("busy_accept", 32'(lsu_busy), 32'd1);
        check("req_with_valid", 32'(mem_req), 32'd0);
        cyc = 0;
        @(negedge clk); cyc++;
        lsu_valid = 1'b0;
        if (!ok) begin
            check("err_done", 32'(lsu_done), 32'd1);
            check("err_misalign", 32'(lsu_misalign), 32'd1);
            check("err_rdata", lsu_rdata, 32'd0);
            check("err_no_req", 32'(mem_req), 32'd0);
            check("err_busy", 32'(lsu_busy), 32'd0);
            @(negedge clk);
            check("err_done_pulse", 32'(lsu_done), 32'd0);
            check("err_no_req2", 32'(mem_req), 32'd0);
            return;
        end
        for (int i = 0; i <= rs; i++) begin
            check("req_high", 32'(mem_req), 32'd1);
            check("req_busy", 32'(lsu_busy), 32'd1);
            check("req_addr", mem_addr, e_addr);
            check("req_we", 32'(mem_we), 32'(wr));
            check("req_strb", 32'(mem_wstrb), 32'(e_strb));
            if (wr) check("req_wdata", mem_wdata, e_wdata);
            mem_ready  = (i == rs);
            mem_rvalid = noise ? 1'($urandom) : 1'b0;
            if (noise) begin
                lsu_valid = 1'($urandom); lsu_write = 1'($urandom);
                mem_opcode = 3'($urandom); lsu_addr = $urandom; lsu_wdata = $urandom;
            end
            @(negedge clk); cyc++;
        end
        mem_ready = 1'b0;
        for (int j = 0; j <= vs; j++) begin
            check("wait_req_low", 32'(mem_req), 32'd0);
            check("wait_busy", 32'(lsu_busy), 32'd1);
            check("wait_no_done", 32'(lsu_done), 32'd0);
            mem_rvalid = (j == vs);
            mem_rdata  = (j == vs) ? rd : $urandom;
            if (noise) begin
                mem_ready = 1'($urandom);
                lsu_valid = 1'($urandom);
            end
            @(negedge clk); cyc++;
        end
        mem_rvalid = 1'b0; mem_ready = 1'b0; lsu_valid = 1'b0;
        check("done", 32'(lsu_done), 32'd1);
        check("done_latency", 32'(cyc), 32'(3 + rs + vs));
        check("done_misalign", 32'(lsu_misalign), 32'd0);
        check("done_rdata", lsu_rdata, e_rdata);
        check("done_busy", 32'(lsu_busy), 32'd0);
        check("done_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        check("done_pulse", 32'(lsu_done), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(lsu_busy), 32'd0);
        check({tag, "_done"}, 32'(lsu_done), 32'd0);
        check({tag, "_rdata"}, lsu_rdata, 32'd0);
        check({tag, "_misalign"}, 32'(lsu_misalign), 32'd0);
        check({tag, "_req"}, 32'(mem_req), 32'd0);
        check({tag, "_we"}, 32'(mem_we), 32'd0);
        check({tag, "_addr"}, mem_addr, 32'd0);
        check({tag, "_wdata"}, mem_wdata, 32'd0);
        check({tag, "_strb"}, 32'(mem_wstrb), 32'd0);
    endtask

    initial begin
        total = 0; passed = 0; fails = 0;
        rst_b = 1'b1; lsu_valid = 1'b0; lsu_write = 1'b0; mem_opcode = 3'd0;
        lsu_addr = '0; lsu_wdata = '0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        #2 rst_b = 1'b0;
        #1 check_all_zero("reset");
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        check("stray_rvalid_done", 32'(lsu_done), 32'd0);
        mem_rvalid = 1'b0;
        @(negedge clk);

        // Directed accesses
        do_access(3'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 1'b0);
        do_access(3'd0, 1'b0, 32'h103, 32'h0, 32'h80112233, 0, 0, 1'b0);
        do_access(3'd4, 1'b0, 32'h103, 32'h0, 32'h80112233, 0, 0, 1'b0);
        do_access(3'd1, 1'b1, 32'h202, 32'h1234ABCD, 32'h0, 0, 0, 1'b0);
        do_access(3'd0, 1'b1, 32'h301, 32'h000000A5, 32'h0, 1, 0, 1'b0);
        do_access(3'd5, 1'b0, 32'h402, 32'h0, 32'h8765_4321, 0, 1, 1'b0);
        do_access(3'd2, 1'b0, 32'h101, 32'h0, 32'h0, 0, 0, 1'b0);
        do_access(3'd4, 1'b1, 32'h104, 32'h55, 32'h0, 0, 0, 1'b0);
        do_access(3'd3, 1'b0, 32'h108, 32'h0, 32'h0, 0, 0, 1'b0);
        do_access(3'd2, 1'b0, 32'h500, 32'h0, 32'hCAFEF00D, 3, 2, 1'b0);

        // Reset while waiting for the response
        lsu_valid = 1'b1; lsu_write = 1'b0; mem_opcode = 3'd2; lsu_addr = 32'h600;
        @(negedge clk);
        lsu_valid = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        check("rstw_in_wait", 32'(mem_req), 32'd0);
        rst_b = 1'b0;
        #1 check_all_zero("rst_wait");
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        check("rstw_no_done", 32'(lsu_done), 32'd0);
        check("rstw_rdata", lsu_rdata, 32'd0);
        mem_rvalid = 1'b0;
        @(negedge clk);
        check("rstw_idle_done", 32'(lsu_done), 32'd0);
        do_access(3'd2, 1'b0, 32'h700, 32'h0, 32'h0BAD_BEEF, 0, 0, 1'b0);

        // Reset while requesting: mem_req must drop without a clock edge
        lsu_valid = 1'b1; lsu_write = 1'b1; mem_opcode = 3'd2; lsu_addr = 32'h800;
        lsu_wdata = 32'h1357_9BDF;
        @(negedge clk);
        lsu_valid = 1'b0;
        check("rstr_req", 32'(mem_req), 32'd1);
        rst_b = 1'b0;
        #1 check_all_zero("rst_req");
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        check("rstr_no_req", 32'(mem_req), 32'd0);
        do_access(3'd1, 1'b0, 32'h902, 32'h0, 32'h8001_7FFF, 1, 1, 1'b0);

        // Randomized accesses with bus stalls and ignored-input noise
        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            a = $urandom;
            if ((n % 4) != 0) a[1:0] = 2'b00;
            do_access(3'($urandom_range(0, 7)), 1'($urandom), a, $urandom, $urandom,
                      $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
